platform1_rst_gen: RTL and testbench
====================================

# platform1_rst_gen

Reset conditioner upstream of the `platform1` LatticeMico8 SoC on MachXO2. It takes the raw board reset pushbutton, debounces it, and produces a clean, stretched, active-low `reset_n_o`. That output drives the SoC's `reset_n` input. An optional watchdog forces the same reset if software stops kicking it. The block runs from the same internal OSCH clock as the platform (24.18 MHz nominal).

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 241800: consecutive stable synced samples needed to accept a button press or release (10 ms). Must be ≥ 2.
- `HOLD_CYCLES`, default 2418: minimum `reset_n_o` low time after any reset source clears (100 µs). Must be ≥ 2.
- `WDT_CYCLES`, default 24180000: watchdog timeout in clocks (1 s). Must be ≥ 2.
- Counter widths are derived with `$clog2`.

Ports:
- `clk_i`, input, 1: platform clock (OSCH output).
- `rst_i`, input, 1: one clock domain; reset is asynchronous and active-high. This is the power-on/global reset.
- `btn_n_i`, input, 1: raw pushbutton, active-low, asynchronous to `clk_i`, bouncing.
- `wdt_kick_i`, input, 1: one-cycle kick pulse from the SoC side, synchronous to `clk_i`.
- `reset_n_o`, output, 1: registered active-low reset to the platform.
- `rst_cause_o`, output, 2: cause of the last reset. 00 = power-on (`rst_i`), 01 = button, 10 = watchdog.

## Operation

- **Synchronizer**: `btn_n_i` passes through 2 flops, giving a 2-cycle latency. Both flops reset to 1 (released).
- **State HOLD**: `reset_n_o` is 0 and the hold counter increments. When the count reaches `HOLD_CYCLES`-1, the block goes to RUN. Every entry into HOLD clears the hold counter.
- **State RUN**: `reset_n_o` is 1. A synced button value of 0 moves the block to DEB_PRESS and clears the debounce counter.
- **State DEB_PRESS**: `reset_n_o` stays 1.
  - A synced value of 1 returns the block to RUN (glitch rejected).
  - `DEBOUNCE_CYCLES` consecutive 0 samples move the block to PRESSED and latch cause 01.
- **State PRESSED**: `reset_n_o` is 0.
  - Each synced 1 sample increments the debounce counter; any 0 sample clears it.
  - Reaching `DEBOUNCE_CYCLES` consecutive 1 samples moves the block to HOLD.
- **Watchdog** (when compiled in):
  - The counter increments in RUN and DEB_PRESS.
  - `wdt_kick_i`=1 clears it.
  - It is held at 0 in HOLD and PRESSED.
  - When the count reaches `WDT_CYCLES`-1 without a kick, the block goes to HOLD with cause 10.
- **Priorities on the same cycle**:
  - `rst_i` overrides everything.
  - Button debounce completion beats watchdog expiry, so the cause is 01.
  - A kick on the expiry cycle wins: the counter clears and no reset occurs.
- **Reset values**: state HOLD, `reset_n_o`=0, `rst_cause_o`=00, all counters 0, sync flops 1.
- **`rst_i` mid-operation**: asserting `rst_i` in any state drives `reset_n_o` low immediately (asynchronously). The block re-enters HOLD with cause 00, and a full `HOLD_CYCLES` stretch follows deassertion.

## Timing

- **After `rst_i` deasserts**: `reset_n_o` rises on the `HOLD_CYCLES`-th rising edge of `clk_i`.
- **Press to reset**: `reset_n_o` falls `DEBOUNCE_CYCLES`+2 edges after the raw button goes low, ±1 edge for asynchronous sampling.
- **Release to run**: `reset_n_o` rises `DEBOUNCE_CYCLES`+2+`HOLD_CYCLES` edges after the raw button goes high and stays high, ±1 edge.
- **Watchdog expiry**: `reset_n_o` falls on the `WDT_CYCLES`-th edge after the last kick or after entry into RUN. It rises `HOLD_CYCLES` edges later.
- **`rst_cause_o`**: updates on the same edge that `reset_n_o` falls. It is stable while `reset_n_o` is high.
- **Glitches**: `reset_n_o` is driven only from a flop (except the asynchronous clear by `rst_i`), so it never glitches.

## Configuration

- Macro: `PLATFORM1_RST_GEN_WATCHDOG_EN`.
- Defined: the watchdog counter and the cause-10 path are present, as described above.
- Undefined:
  - No watchdog counter is built.
  - `wdt_kick_i` is still present but ignored.
  - `rst_cause_o` never reads 10.
  - All other behaviour is identical.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=16, `HOLD_CYCLES`=8, `WDT_CYCLES`=100, macro defined.

1. **Power-on**: `rst_i`=1 for 5 cycles, then 0 → `reset_n_o`=0 and cause 00 throughout reset. `reset_n_o` rises on edge 8 after release.
2. **Glitch rejection**: `btn_n_i` low for 10 cycles, then high → `reset_n_o` stays 1 and cause stays 00.
3. **Valid press**: `btn_n_i` low for 40 cycles, then high → `reset_n_o` falls 18±1 edges after the press and cause becomes 01. `reset_n_o` rises 26±1 edges after release.
4. **Watchdog**:
   - No kicks after RUN → `reset_n_o` falls on edge 100, cause 10, and rises 8 edges later.
   - A kick every 50 cycles → no reset over 1000 cycles.
   - A kick on cycle 99 → no reset.
5. **Reset mid-press**: `rst_i` pulsed for 2 cycles during PRESSED → `reset_n_o`=0 asynchronously and cause 00. The block returns to RUN 8 edges after `rst_i` falls, with the button released.
6. **Macro undefined**: no kicks for 500 cycles → `reset_n_o` stays 1 and cause never reads 10.

Source files
------------

// File: rtl/platform1_rst_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : platform1_rst_gen
// Purpose  : Reset conditioner for the platform1 LatticeMico8 SoC. Debounces
//            the raw board pushbutton and stretches every reset. It produces a
//            glitch-free, registered active-low reset_n_o for the SoC. An
//            optional watchdog can force the same reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    :
//   clk_i        in   1  platform clock (OSCH, 24.18 MHz nominal)
//   rst_i        in   1  power-on/global reset, asynchronous, active-high
//   btn_n_i      in   1  raw pushbutton, active-low, asynchronous, bouncing
//   wdt_kick_i   in   1  one-cycle watchdog kick, synchronous to clk_i
//   reset_n_o    out  1  registered active-low reset to the platform
//   rst_cause_o  out  2  cause of last reset: 00 power-on, 01 button,
//                        10 watchdog
// Parameters (each must be >= 2):
//   DEBOUNCE_CYCLES  stable synced samples to accept a press/release
//   HOLD_CYCLES      minimum reset_n_o low time after a source clears
//   WDT_CYCLES       watchdog timeout in clocks
// Build option:
//   PLATFORM1_RST_GEN_WATCHDOG_EN  define to build the watchdog. When it is
//   undefined, wdt_kick_i is ignored and rst_cause_o never reads 10.
// ============================================================================
module platform1_rst_gen #(
   parameter int DEBOUNCE_CYCLES = 241800,
   parameter int HOLD_CYCLES     = 2418,
   parameter int WDT_CYCLES      = 24180000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_n_i,
   input  logic       wdt_kick_i,
   output logic       reset_n_o,
   output logic [1:0] rst_cause_o
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int c_HOLD_W = $clog2(HOLD_CYCLES);

   // Last count before a debounce completes while in PRESSED. In that state
   // every counted sample sits in the counter.
   localparam logic [c_DEB_W-1:0]  c_DEB_LAST     = c_DEB_W'(DEBOUNCE_CYCLES - 1);
   // In DEB_PRESS, the low sample that caused entry from RUN counts as the
   // first sample. Completion therefore comes one count earlier.
   localparam logic [c_DEB_W-1:0]  c_DEB_PRE_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST    = c_HOLD_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] c_CAUSE_POR = 2'b00;
   localparam logic [1:0] c_CAUSE_BTN = 2'b01;
   localparam logic [1:0] c_CAUSE_WDT = 2'b10;

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_RUN       = 2'd1,
      ST_DEB_PRESS = 2'd2,
      ST_PRESSED   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [1:0]          r_sync;
   logic                w_btn_n;

   state_t              r_state;
   logic                r_reset_n;
   logic [1:0]          r_cause;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [c_DEB_W-1:0]  r_deb_cnt;

   logic                w_deb_done;
   logic                w_wdt_expire;

   // ------------------------------------------------------------------------
   // Button synchronizer. It resets to "released" so that a reset never
   // looks like a press.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], btn_n_i};
      end
   end

   assign w_btn_n = r_sync[1];

   // The press debounce completes on this cycle. It takes priority over a
   // watchdog expiry on the same cycle, so the cause reads as button.
   assign w_deb_done = (r_state == ST_DEB_PRESS) && !w_btn_n &&
                       (r_deb_cnt == c_DEB_PRE_LAST);

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
`ifdef PLATFORM1_RST_GEN_WATCHDOG_EN
   localparam int c_WDT_W = $clog2(WDT_CYCLES);
   localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(WDT_CYCLES - 1);

   logic [c_WDT_W-1:0] r_wdt_cnt;
   logic               w_wdt_active;

   // The counter runs only while the SoC is out of reset. DEB_PRESS counts
   // because the SoC is still running during a possible press.
   assign w_wdt_active = (r_state == ST_RUN) || (r_state == ST_DEB_PRESS);

   // A kick on the terminal count wins and no reset occurs.
   assign w_wdt_expire = w_wdt_active && !wdt_kick_i && (r_wdt_cnt == c_WDT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wdt_cnt <= '0;
      end else if (!w_wdt_active || wdt_kick_i || w_wdt_expire || w_deb_done) begin
         // Clearing on expiry or debounce completion keeps the counter at 0
         // for the whole stay in HOLD/PRESSED, including the first cycle.
         r_wdt_cnt <= '0;
      end else begin
         r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
   end
`else
   // Without the watchdog, the kick input and the timeout are unused.
   localparam int c_unused_wdt_cycles = WDT_CYCLES;
   logic w_unused_kick;

   assign w_unused_kick = wdt_kick_i;
   assign w_wdt_expire  = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Reset sequencing FSM. reset_n_o and rst_cause_o are registered here and
   // change together on the edge where a reset is entered.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_HOLD;
         r_reset_n  <= 1'b0;
         r_cause    <= c_CAUSE_POR;
         r_hold_cnt <= '0;
         r_deb_cnt  <= '0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               // Stretch: count out the minimum low time, then release.
               if (r_hold_cnt == c_HOLD_LAST) begin
                  r_state    <= ST_RUN;
                  r_reset_n  <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end

            ST_RUN: begin
               if (w_wdt_expire) begin
                  r_state    <= ST_HOLD;
                  r_reset_n  <= 1'b0;
                  r_cause    <= c_CAUSE_WDT;
                  r_hold_cnt <= '0;
               end else if (!w_btn_n) begin
                  r_state   <= ST_DEB_PRESS;
                  r_deb_cnt <= '0;
               end
            end

            ST_DEB_PRESS: begin
               if (w_deb_done) begin
                  r_state   <= ST_PRESSED;
                  r_reset_n <= 1'b0;
                  r_cause   <= c_CAUSE_BTN;
                  r_deb_cnt <= '0;
               end else if (w_wdt_expire) begin
                  r_state    <= ST_HOLD;
                  r_reset_n  <= 1'b0;
                  r_cause    <= c_CAUSE_WDT;
                  r_hold_cnt <= '0;
               end else if (w_btn_n) begin
                  // Bounce or glitch: the press was not stable long enough.
                  r_state <= ST_RUN;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end

            ST_PRESSED: begin
               // Release debounce: any low sample restarts the count.
               if (w_btn_n) begin
                  if (r_deb_cnt == c_DEB_LAST) begin
                     r_state    <= ST_HOLD;
                     r_hold_cnt <= '0;
                     r_deb_cnt  <= '0;
                  end else begin
                     r_deb_cnt <= r_deb_cnt + 1'b1;
                  end
               end else begin
                  r_deb_cnt <= '0;
               end
            end

            default: begin
               r_state    <= ST_HOLD;
               r_reset_n  <= 1'b0;
               r_hold_cnt <= '0;
            end
         endcase
      end
   end

   assign reset_n_o   = r_reset_n;
   assign rst_cause_o = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_platform1_rst_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_platform1_rst_gen
// Purpose  : Directed self-checking bench for platform1_rst_gen with
//            DEBOUNCE_CYCLES=16, HOLD_CYCLES=8, WDT_CYCLES=100. Inputs change
//            1 ns after a rising edge, and outputs are sampled at that point.
//            "Edge n" counts rising edges after the input change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_platform1_rst_gen;

   localparam int DEB  = 16;
   localparam int HOLD = 8;
   localparam int WDT  = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_n;
   logic       kick;
   logic       reset_n;
   logic [1:0] cause;

   int   checks = 0;
   int   errors = 0;
   int   edge_n;
   logic seen;

   always #5 clk = ~clk;

   platform1_rst_gen #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLD_CYCLES     (HOLD),
      .WDT_CYCLES      (WDT)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_n_i     (btn_n),
      .wdt_kick_i  (kick),
      .reset_n_o   (reset_n),
      .rst_cause_o (cause)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic kick_pulse();
      kick = 1'b1;
      tick(1);
      kick = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- 1. power-on ----------------
      rst   = 1'b1;
      btn_n = 1'b1;
      kick  = 1'b0;
      #1;
      check("por_rst_n_t0", reset_n, 0);
      check("por_cause_t0", cause, 2'b00);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("por_rst_n_in_reset", reset_n, 0);
         check("por_cause_in_reset", cause, 2'b00);
      end
      rst = 1'b0;
      tick(HOLD - 1);
      check("por_rst_n_edge7", reset_n, 0);
      tick(1);
      check("por_rst_n_edge8", reset_n, 1);
      check("por_cause_run", cause, 2'b00);

      // ---------------- 2. glitch rejection ----------------
      kick_pulse();
      btn_n = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (reset_n !== 1'b1) seen = 1'b1;
      end
      btn_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (reset_n !== 1'b1) seen = 1'b1;
      end
      check("glitch_no_reset", seen, 0);
      check("glitch_cause", cause, 2'b00);

      // ---------------- 3. valid press ----------------
      kick_pulse();
      btn_n  = 1'b0;
      edge_n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (reset_n === 1'b0 && edge_n == 0) edge_n = i;
      end
      check("press_fall_edge_17_to_19", (edge_n >= DEB + 1 && edge_n <= DEB + 3), 1);
      check("press_cause", cause, 2'b01);
      check("press_rst_n_held", reset_n, 0);
      btn_n  = 1'b1;
      edge_n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (reset_n === 1'b1) begin
            edge_n = i;
            break;
         end
      end
      check("release_rise_edge_25_to_27",
            (edge_n >= DEB + HOLD + 1 && edge_n <= DEB + HOLD + 3), 1);
      check("release_cause_stable", cause, 2'b01);

`ifdef PLATFORM1_RST_GEN_WATCHDOG_EN
      // ---------------- 4. watchdog ----------------
      edge_n = 0;
      for (int i = 1; i <= WDT + 20; i++) begin
         tick(1);
         if (reset_n === 1'b0) begin
            edge_n = i;
            break;
         end
      end
      check("wdt_fall_edge", edge_n, WDT);
      check("wdt_cause", cause, 2'b10);
      edge_n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (reset_n === 1'b1) begin
            edge_n = i;
            break;
         end
      end
      check("wdt_rise_edge", edge_n, HOLD);
      check("wdt_cause_stable", cause, 2'b10);

      // Kick every 50 cycles over 1000 cycles.
      seen = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         tick(1);
         if (reset_n !== 1'b1) seen = 1'b1;
         kick = (i % 50 == 0);
      end
      check("wdt_periodic_kick_no_reset", seen, 0);

      // Kick on the terminal-count edge suppresses the expiry.
      tick(1);
      kick = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < WDT - 1; i++) begin
         tick(1);
         if (reset_n !== 1'b1) seen = 1'b1;
      end
      kick = 1'b1;
      tick(1);
      if (reset_n !== 1'b1) seen = 1'b1;
      kick = 1'b0;
      check("wdt_kick_on_expiry_no_reset", seen, 0);
      edge_n = 0;
      for (int i = 1; i <= WDT + 20; i++) begin
         tick(1);
         if (reset_n === 1'b0) begin
            edge_n = i;
            break;
         end
      end
      check("wdt_fall_after_late_kick", edge_n, WDT);
      edge_n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (reset_n === 1'b1) begin
            edge_n = i;
            break;
         end
      end
      check("wdt_rise_after_late_kick", edge_n, HOLD);
`else
      // ---------------- 6. watchdog not built ----------------
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick(1);
         if (reset_n !== 1'b1 || cause === 2'b10) seen = 1'b1;
      end
      check("nowdt_no_reset", seen, 0);
      check("nowdt_cause", cause, 2'b01);
`endif

      // ---------------- 5. reset mid-press ----------------
      kick_pulse();
      btn_n  = 1'b0;
      edge_n = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (reset_n === 1'b0) begin
            edge_n = i;
            break;
         end
      end
      check("midpress_fall_edge_17_to_19", (edge_n >= DEB + 1 && edge_n <= DEB + 3), 1);
      check("midpress_cause_btn", cause, 2'b01);
      #2;
      rst   = 1'b1;
      btn_n = 1'b1;
      #1;
      check("midpress_async_cause", cause, 2'b00);
      check("midpress_async_rst_n", reset_n, 0);
      tick(2);
      rst = 1'b0;
      tick(HOLD - 1);
      check("midpress_rst_n_edge7", reset_n, 0);
      tick(1);
      check("midpress_rst_n_edge8", reset_n, 1);
      check("midpress_cause_por", cause, 2'b00);

      // rst_i asserted in RUN clears reset_n_o without waiting for an edge.
      #2;
      rst = 1'b1;
      #1;
      check("run_async_rst_n", reset_n, 0);
      check("run_async_cause", cause, 2'b00);
      tick(1);
      rst = 1'b0;
      tick(HOLD);
      check("run_rst_rise_edge8", reset_n, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
